b10_link_partner: RTL and testbench

- Synthesizable far-end partner for the b10 voting controller's two handshakes.
- Drives rts/rtr/v_in and consumes cts/ctr/v_out, replacing hand-coded opcode stimulus with protocol-correct four-phase transfers.
- TX side: small FIFO of 4-bit words pushed into b10 via rts/cts.
- RX side: pulls 4-bit words out of b10 via rtr/ctr. Used in system benches and FPGA bring-up.

---
 rtl/b10_link_partner.sv | 146 ++++++++++++++
 tb/tb_b10_link_partner.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b10_link_partner.sv
// b10_link_partner: far-end partner for the b10 rts/cts and rtr/ctr four-phase handshakes.
module b10_link_partner #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_valid_i,
  input  logic [3:0] tx_data_i,
  output logic       tx_ready_o,
  input  logic       rx_req_i,
  output logic       rx_valid_o,
  output logic [3:0] rx_data_o,
  input  logic       err_clr_i,
  output logic       tx_timeout_o,
  output logic       rx_timeout_o,
  output logic       busy_o,
  output logic       rts_o,
  output logic       rtr_o,
  output logic [3:0] v_in_o,
  input  logic       cts_i,
  input  logic       ctr_i,
  input  logic [3:0] v_out_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} t_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} r_state_e;
  t_state_e t_q, t_d;
  r_state_e r_q, r_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    tcnt_q, tcnt_d, rcnt_q, rcnt_d;
  logic [3:0]    v_in_q, v_in_d, rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, tx_to_q, tx_to_d, rx_to_q, rx_to_d;
  logic          push, pop;
  assign tx_ready_o   = cnt_q != CW'(DEPTH);
  assign push         = tx_valid_i & tx_ready_o;
  assign rts_o        = t_q == T_REQ;
  assign rtr_o        = r_q == R_REQ;
  assign v_in_o       = v_in_q;
  assign rx_valid_o   = rx_valid_q;
  assign rx_data_o    = rx_data_q;
  assign tx_timeout_o = tx_to_q;
  assign rx_timeout_o = rx_to_q;
  assign busy_o       = (t_q != T_IDLE) | (r_q != R_IDLE) | (cnt_q != '0);
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= tx_data_i;
  end
  // A timed-out request leaves the head word in place so it is retried.
  always_comb begin
    t_d     = t_q;
    tcnt_d  = tcnt_q + 8'd1;
    v_in_d  = v_in_q;
    pop     = 1'b0;
    tx_to_d = err_clr_i ? 1'b0 : tx_to_q;
    case (t_q)
      T_IDLE: begin
        tcnt_d = '0;
        if (cnt_q != '0) begin
          t_d    = T_REQ;
          v_in_d = mem_q[rd_q];
        end
      end
      T_REQ: begin
        if (cts_i) begin
          pop    = 1'b1;
          t_d    = T_REL;
          tcnt_d = '0;
        end else if (tcnt_q == TLAST) begin
          t_d     = T_IDLE;
          v_in_d  = '0;
          tx_to_d = 1'b1;
        end
      end
      T_REL: begin
        if (!cts_i || tcnt_q == TLAST) begin
          t_d    = T_IDLE;
          v_in_d = '0;
        end
        if (cts_i && tcnt_q == TLAST) tx_to_d = 1'b1;
      end
      default: t_d = T_IDLE;
    endcase
  end
  always_comb begin
    r_d        = r_q;
    rcnt_d     = rcnt_q + 8'd1;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_to_d    = err_clr_i ? 1'b0 : rx_to_q;
    case (r_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (rx_req_i) r_d = R_REQ;
      end
      R_REQ: begin
        if (ctr_i) begin
          r_d        = R_REL;
          rcnt_d     = '0;
          rx_data_d  = v_out_i;
          rx_valid_d = 1'b1;
        end else if (rcnt_q == TLAST) begin
          r_d     = R_IDLE;
          rx_to_d = 1'b1;
        end
      end
      R_REL: begin
        if (!ctr_i || rcnt_q == TLAST) r_d = R_IDLE;
        if (ctr_i && rcnt_q == TLAST) rx_to_d = 1'b1;
      end
      default: r_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t_q        <= T_IDLE;
      r_q        <= R_IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      rcnt_q     <= '0;
      v_in_q     <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_to_q    <= 1'b0;
      rx_to_q    <= 1'b0;
    end else begin
      t_q        <= t_d;
      r_q        <= r_d;
      wr_q       <= wr_q + AW'(push);
      rd_q       <= rd_q + AW'(pop);
      cnt_q      <= cnt_q + CW'(push) - CW'(pop);
      tcnt_q     <= tcnt_d;
      rcnt_q     <= rcnt_d;
      v_in_q     <= v_in_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_to_q    <= tx_to_d;
      rx_to_q    <= rx_to_d;
    end
  end
endmodule

// File: tb/tb_b10_link_partner.sv
// tb_b10_link_partner: randomized handshake bench with a word-queue model of the TX FIFO.
module tb_b10_link_partner;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 255;
  logic clk = 0, rst_n = 0, tx_valid = 0, rx_req = 0, err_clr = 0, cts = 0, ctr = 0;
  logic [3:0] tx_data = 0, v_out = 0;
  logic tx_ready, rx_valid, tx_to, rx_to, busy, rts, rtr;
  logic [3:0] rx_data, v_in;
  int checks = 0, failures = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  b10_link_partner #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
    .tx_ready_o(tx_ready), .rx_req_i(rx_req), .rx_valid_o(rx_valid), .rx_data_o(rx_data),
    .err_clr_i(err_clr), .tx_timeout_o(tx_to), .rx_timeout_o(rx_to), .busy_o(busy),
    .rts_o(rts), .rtr_o(rtr), .v_in_o(v_in), .cts_i(cts), .ctr_i(ctr), .v_out_i(v_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: a push is accepted only while fewer than DEPTH words are outstanding.
  task automatic push(input logic [3:0] w);
    logic acc;
    acc = exp_q.size() < DEPTH;
    checks++;
    if (tx_ready !== acc) begin
      failures++;
      $display("FAIL push_ready act=%0b exp=%0b", tx_ready, acc);
    end
    tx_valid = 1; tx_data = w;
    tick;
    tx_valid = 0;
    if (acc) exp_q.push_back(w);
  endtask

  task automatic tx_xfer(input int d_assert, input int d_release, output int wait_n);
    logic [3:0] w;
    w = exp_q.size() != 0 ? exp_q[0] : 4'h0;
    wait_n = 0;
    while (!rts && wait_n < 20) begin tick; wait_n++; end
    checks++;
    if (rts !== 1'b1 || v_in !== w) begin
      failures++;
      $display("FAIL tx_req rts=%0b v_in=%h exp rts=1 v_in=%h", rts, v_in, w);
    end
    repeat (d_assert) begin
      tick;
      checks++;
      if (rts !== 1'b1 || v_in !== w) begin
        failures++;
        $display("FAIL tx_hold rts=%0b v_in=%h exp rts=1 v_in=%h", rts, v_in, w);
      end
    end
    cts = 1;
    tick;
    if (exp_q.size() != 0) exp_q.delete(0);
    checks++;
    if (rts !== 1'b0 || v_in !== w) begin
      failures++;
      $display("FAIL tx_ack rts=%0b v_in=%h exp rts=0 v_in=%h", rts, v_in, w);
    end
    repeat (d_release) begin
      tick;
      checks++;
      if (rts !== 1'b0 || v_in !== w) begin
        failures++;
        $display("FAIL tx_rel rts=%0b v_in=%h exp rts=0 v_in=%h", rts, v_in, w);
      end
    end
    cts = 0;
    tick;
    checks++;
    if (rts !== 1'b0 || v_in !== 4'h0) begin
      failures++;
      $display("FAIL tx_done rts=%0b v_in=%h exp rts=0 v_in=0", rts, v_in);
    end
  endtask

  task automatic rx_xfer(input logic [3:0] w, input int delay, input bit drop_req);
    int n;
    n = 0;
    while (!rtr && n < 20) begin tick; n++; end
    checks++;
    if (rtr !== 1'b1) begin
      failures++;
      $display("FAIL rx_req rtr=%0b exp=1", rtr);
    end
    if (drop_req) rx_req = 0;
    repeat (delay) begin
      tick;
      checks++;
      if (rtr !== 1'b1 || rx_valid !== 1'b0) begin
        failures++;
        $display("FAIL rx_hold rtr=%0b rx_valid=%0b exp 1/0", rtr, rx_valid);
      end
    end
    ctr = 1; v_out = w;
    tick;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== w || rtr !== 1'b0) begin
      failures++;
      $display("FAIL rx_capture valid=%0b data=%h rtr=%0b exp 1/%h/0", rx_valid, rx_data, rtr, w);
    end
    v_out = 4'($urandom);
    tick;
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== w) begin
      failures++;
      $display("FAIL rx_pulse valid=%0b data=%h exp 0/%h", rx_valid, rx_data, w);
    end
    ctr = 0;
    tick;
    checks++;
    if (rtr !== 1'b0) begin
      failures++;
      $display("FAIL rx_release rtr=%0b exp=0", rtr);
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({tx_ready, rts, rtr, v_in, rx_valid, rx_data, tx_to, rx_to, busy} !== {1'b1, 14'b0}) begin
      failures++;
      $display("FAIL reset_outputs act=%b exp=%b", {tx_ready, rts, rtr, v_in, rx_valid, rx_data, tx_to, rx_to, busy}, {1'b1, 14'b0});
    end
    #1 rst_n = 1;
    tick;
    tick;
    checks++;
    if ({tx_ready, rts, rtr, v_in, rx_valid, rx_data, tx_to, rx_to, busy} !== {1'b1, 14'b0}) begin
      failures++;
      $display("FAIL idle_outputs act=%b exp=%b", {tx_ready, rts, rtr, v_in, rx_valid, rx_data, tx_to, rx_to, busy}, {1'b1, 14'b0});
    end
  endtask

  task automatic test_single;
    int n;
    push(4'hA);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy act=%0b exp=1", busy);
    end
    tx_xfer(3, 2, n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL rts_latency act=%0d exp=1", n);
    end
    checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle busy=%0b tx_ready=%0b exp 0/1", busy, tx_ready);
    end
  endtask

  task automatic test_fill;
    int n, k;
    for (int i = 1; i <= 4; i++) push(4'(i));
    checks++;
    if (tx_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready act=%0b exp=0", tx_ready);
    end
    push(4'hF);
    for (int i = 0; i < 4; i++) tx_xfer($urandom_range(0, 4), $urandom_range(0, 3), n);
    k = $urandom_range(1, DEPTH);
    for (int i = 0; i < k; i++) begin
      push(4'($urandom));
      repeat ($urandom_range(0, 2)) tick;
    end
    for (int i = 0; i < k; i++) tx_xfer($urandom_range(0, 4), $urandom_range(0, 3), n);
    checks++;
    if (busy !== 1'b0 || rts !== 1'b0) begin
      failures++;
      $display("FAIL fill_drained busy=%0b rts=%0b exp 0/0", busy, rts);
    end
  endtask

  task automatic test_rx;
    rx_req = 1;
    rx_xfer(4'h6, $urandom_range(0, 3), 0);
    rx_xfer(4'h9, $urandom_range(0, 3), 0);
    rx_xfer(4'($urandom), $urandom_range(0, 3), 1);
    tick;
    checks++;
    if (rtr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rx_stop rtr=%0b busy=%0b exp 0/0", rtr, busy);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic [3:0] w;
    w = 4'($urandom);
    push(w);
    n = 0;
    while (!rts && n < 20) begin tick; n++; end
    n = 0;
    while (rts && n < 300) begin n++; tick; end
    checks++;
    if (n != TIMEOUT || tx_to !== 1'b1 || v_in !== 4'h0) begin
      failures++;
      $display("FAIL tx_timeout cycles=%0d flag=%0b v_in=%h exp %0d/1/0", n, tx_to, v_in, TIMEOUT);
    end
    tick;
    checks++;
    if (rts !== 1'b1 || v_in !== w || tx_to !== 1'b1) begin
      failures++;
      $display("FAIL tx_retry rts=%0b v_in=%h flag=%0b exp 1/%h/1", rts, v_in, tx_to, w);
    end
    err_clr = 1;
    tick;
    err_clr = 0;
    checks++;
    if (tx_to !== 1'b0) begin
      failures++;
      $display("FAIL tx_err_clr act=%0b exp=0", tx_to);
    end
    tx_xfer(1, 0, n);
    err_clr = 1; rx_req = 1;
    n = 0;
    while (!rtr && n < 20) begin tick; n++; end
    rx_req = 0;
    n = 0;
    while (rtr && n < 300) begin n++; tick; end
    checks++;
    if (n != TIMEOUT || rx_to !== 1'b1 || tx_to !== 1'b0) begin
      failures++;
      $display("FAIL rx_timeout cycles=%0d rx_flag=%0b tx_flag=%0b exp %0d/1/0", n, rx_to, tx_to, TIMEOUT);
    end
    tick;
    err_clr = 0;
    checks++;
    if (rx_to !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rx_err_clr flag=%0b busy=%0b exp 0/0", rx_to, busy);
    end
  endtask

  task automatic test_concurrent;
    int n;
    logic [3:0] r;
    push(4'($urandom));
    rx_req = 1;
    n = 0;
    while (!(rts && rtr) && n < 20) begin tick; n++; end
    checks++;
    if (rts !== 1'b1 || rtr !== 1'b1) begin
      failures++;
      $display("FAIL both_req rts=%0b rtr=%0b exp 1/1", rts, rtr);
    end
    rx_req = 0;
    r = 4'($urandom);
    cts = 1; ctr = 1; v_out = r;
    tick;
    exp_q.delete(0);
    checks++;
    if (rts !== 1'b0 || rtr !== 1'b0 || rx_valid !== 1'b1 || rx_data !== r) begin
      failures++;
      $display("FAIL both_ack rts=%0b rtr=%0b valid=%0b data=%h exp 0/0/1/%h", rts, rtr, rx_valid, rx_data, r);
    end
    cts = 0; ctr = 0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || rts !== 1'b0 || rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL both_done busy=%0b rts=%0b valid=%0b exp 0/0/0", busy, rts, rx_valid);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    push(4'($urandom));
    n = 0;
    while (!rts && n < 20) begin tick; n++; end
    #2 rst_n = 0;
    #1;
    exp_q.delete();
    checks++;
    if (rts !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1 || v_in !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid rts=%0b busy=%0b tx_ready=%0b v_in=%h exp 0/0/1/0", rts, busy, tx_ready, v_in);
    end
    #2 rst_n = 1;
    repeat (3) tick;
    checks++;
    if (rts !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard rts=%0b busy=%0b exp 0/0", rts, busy);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_rx;
    test_timeout;
    test_concurrent;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
